// File: rtl/mem_stage_if.sv
// Bundle of the signals around the MEM stage. It covers the EX-stage
// request, the stall back to the pipeline, the external SRAM bus and
// the registered write-back outputs.
// The slave side is the stage itself. The master side is everything
// around it: the pipeline, the SRAM and the WB stage.
interface mem_stage_if;
  // EX -> MEM
  logic [31:0] result_i;
  logic [31:0] mem_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        load_byte_i;
  logic        reg_write_i;
  logic [4:0]  write_reg_i;
  // stall back to IF/ID/EX
  logic        mem_busy;
  // SRAM bus
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [3:0]  ram_be_n;
  // MEM -> WB
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  modport slave (
    input  result_i, mem_data_i, mem_read_i, mem_write_i, load_byte_i,
           reg_write_i, write_reg_i, ram_rdata,
    output mem_busy, ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n,
           ram_be_n, wb_reg_write, wb_reg, wb_data
  );

  modport master (
    output result_i, mem_data_i, mem_read_i, mem_write_i, load_byte_i,
           reg_write_i, write_reg_i, ram_rdata,
    input  mem_busy, ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n,
           ram_be_n, wb_reg_write, wb_reg, wb_data
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage. It runs multi-cycle loads and stores against an
// asynchronous 32-bit SRAM and stalls the pipeline while an access is
// in flight. Non-memory instructions reach WB with one cycle of latency.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access; pass-through, or accept a request (write wins)
// RD    | ce_n/oe_n low, counting down RD_WAIT cycles, sample data at 0
// WR    | ce_n/we_n low, counting down WR_WAIT cycles
// DONE  | strobes released, addr/wdata held, WB takes the access result
module mem_stage #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input logic     clk,
  input logic     rst_n,
  mem_stage_if.slave bus
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take;
  logic             sample_rd;
  logic             req;
  logic             busy;

  // latched request fields, held for the whole access including DONE
  logic [21:0]      addr_q;
  logic [31:0]      data_q;
  logic             byte_q;
  logic             load_q;
  logic             regw_q;
  logic [4:0]       wreg_q;
  logic [31:0]      rdata_q;

  logic [7:0]       rd_byte;
  logic [31:0]      load_data;

  assign req = bus.mem_read_i | bus.mem_write_i;

  // state and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic; the counter is reloaded on every RD/WR entry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    sample_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_write_i) begin
          state_d = WR;
          cnt_d   = CNT_W'(WR_WAIT - 1);
          take    = 1'b1;
        end else if (bus.mem_read_i) begin
          state_d = RD;
          cnt_d   = CNT_W'(RD_WAIT - 1);
          take    = 1'b1;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          sample_rd = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture the request on acceptance and the read word on the last RD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      byte_q  <= 1'b0;
      load_q  <= 1'b0;
      regw_q  <= 1'b0;
      wreg_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        addr_q <= bus.result_i[21:0];
        data_q <= bus.mem_data_i;
        byte_q <= bus.load_byte_i;
        load_q <= ~bus.mem_write_i;
        regw_q <= bus.reg_write_i;
        wreg_q <= bus.write_reg_i;
      end
      if (sample_rd) begin
        rdata_q <= bus.ram_rdata;
      end
    end
  end

  // Address and data come straight from the latches. They therefore stay
  // stable through DONE, which gives hold time after we_n rises. Strobes
  // decode from the state register, so reset releases them at once.
  assign bus.ram_addr  = addr_q[21:2];
  assign bus.ram_wdata = byte_q ? {4{data_q[7:0]}} : data_q;

  // SRAM strobe decode
  always_comb begin
    bus.ram_ce_n = 1'b1;
    bus.ram_oe_n = 1'b1;
    bus.ram_we_n = 1'b1;
    bus.ram_be_n = 4'hF;
    case (state_q)
      RD: begin
        bus.ram_ce_n = 1'b0;
        bus.ram_oe_n = 1'b0;
        bus.ram_be_n = 4'h0;
      end
      WR: begin
        bus.ram_ce_n = 1'b0;
        bus.ram_we_n = 1'b0;
        bus.ram_be_n = byte_q ? ~(4'b0001 << addr_q[1:0]) : 4'h0;
      end
      default: ;
    endcase
  end

  // The stall covers the accepting IDLE cycle and the strobe phase. DONE is
  // not stalled, so upstream may advance while WB takes the result.
  assign busy = ((state_q == IDLE) && req) || (state_q == RD) || (state_q == WR);
  assign bus.mem_busy = busy;

  // little-endian byte select from the held read word, then load extension
  always_comb begin
    rd_byte = rdata_q[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = rdata_q[7:0];
      2'd1: rd_byte = rdata_q[15:8];
      2'd2: rd_byte = rdata_q[23:16];
      2'd3: rd_byte = rdata_q[31:24];
      default: ;
    endcase
    load_data = byte_q ? {{24{rd_byte[7]}}, rd_byte} : rdata_q;
  end

  // Write-back registers advance on every unstalled edge. The source is the
  // access result in DONE, otherwise the pass-through fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_reg_write <= 1'b0;
      bus.wb_reg       <= '0;
      bus.wb_data      <= '0;
    end else if (!busy) begin
      if (state_q == DONE) begin
        bus.wb_reg_write <= regw_q;
        bus.wb_reg       <= wreg_q;
        bus.wb_data      <= load_q ? load_data : {10'b0, addr_q};
      end else begin
        bus.wb_reg_write <= bus.reg_write_i;
        bus.wb_reg       <= bus.write_reg_i;
        bus.wb_data      <= bus.result_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for the MEM stage. Expected values are hand-computed from
// the access rules: word address = addr[21:2], little-endian byte lanes,
// and sign-extended byte loads.
module tb_mem_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // per-access observations collected while mem_busy is high
  int          busy_cnt, ce_cnt, oe_cnt, we_cnt;
  logic [19:0] seen_addr;
  logic [31:0] seen_wdata;
  logic [3:0]  seen_be;

  mem_stage_if ifc();

  mem_stage #(.RD_WAIT(2), .WR_WAIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr, input logic lb,
                         input logic rw, input logic [4:0] rg);
    ifc.result_i    = addr;
    ifc.mem_data_i  = wdata;
    ifc.mem_read_i  = rd;
    ifc.mem_write_i = wr;
    ifc.load_byte_i = lb;
    ifc.reg_write_i = rw;
    ifc.write_reg_i = rg;
  endtask

  task automatic clear_req();
    set_req(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Steps cycles while the stage stalls and records the strobe activity.
  // It returns in the first unstalled cycle, which is DONE.
  task automatic run_access(input string tag);
    int guard;
    busy_cnt = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; guard = 0;
    seen_addr = '0; seen_wdata = '0; seen_be = 4'hF;
    while (ifc.mem_busy && guard < 40) begin
      busy_cnt++;
      if (!ifc.ram_ce_n) begin
        ce_cnt++;
        seen_addr = ifc.ram_addr;
        seen_be   = ifc.ram_be_n;
      end
      if (!ifc.ram_oe_n) oe_cnt++;
      if (!ifc.ram_we_n) begin
        we_cnt++;
        seen_wdata = ifc.ram_wdata;
      end
      tick();
      guard++;
    end
    if (guard >= 40) chk({tag, " busy timeout"}, 32'(guard), 32'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifc.ram_rdata = 32'h0;
    clear_req();
    #12;
    chk("rst ce_n", 32'(ifc.ram_ce_n), 32'h1);
    chk("rst oe_n", 32'(ifc.ram_oe_n), 32'h1);
    chk("rst we_n", 32'(ifc.ram_we_n), 32'h1);
    chk("rst be_n", 32'(ifc.ram_be_n), 32'hF);
    chk("rst addr", 32'(ifc.ram_addr), 32'h0);
    chk("rst wdata", ifc.ram_wdata, 32'h0);
    chk("rst wb_rw", 32'(ifc.wb_reg_write), 32'h0);
    chk("rst wb_data", ifc.wb_data, 32'h0);
    chk("rst busy", 32'(ifc.mem_busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // pass-through
    set_req(32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    chk("pt busy", 32'(ifc.mem_busy), 32'h0);
    tick();
    chk("pt wb_data", ifc.wb_data, 32'h12345678);
    chk("pt wb_reg", 32'(ifc.wb_reg), 32'd5);
    chk("pt wb_rw", 32'(ifc.wb_reg_write), 32'h1);

    // LW 0x104
    ifc.ram_rdata = 32'hDEADBEEF;
    set_req(32'h00000104, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
    #1;
    chk("lw busy0", 32'(ifc.mem_busy), 32'h1);
    chk("lw ce idle", 32'(ifc.ram_ce_n), 32'h1);
    run_access("lw");
    chk("lw busy cycles", 32'(busy_cnt), 32'd3);
    chk("lw ce cycles", 32'(ce_cnt), 32'd2);
    chk("lw oe cycles", 32'(oe_cnt), 32'd2);
    chk("lw we cycles", 32'(we_cnt), 32'd0);
    chk("lw addr", 32'(seen_addr), 32'h00041);
    chk("lw be", 32'(seen_be), 32'h0);
    chk("lw done ce", 32'(ifc.ram_ce_n), 32'h1);
    chk("lw wb before", ifc.wb_data, 32'h12345678);
    clear_req();
    tick();
    chk("lw wb_data", ifc.wb_data, 32'hDEADBEEF);
    chk("lw wb_reg", 32'(ifc.wb_reg), 32'd7);
    chk("lw wb_rw", 32'(ifc.wb_reg_write), 32'h1);

    // LB at 0x103 (top lane, negative) and at 0x100 (bottom lane, positive)
    ifc.ram_rdata = 32'h80FF0011;
    set_req(32'h00000103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    #1;
    run_access("lb3");
    clear_req();
    tick();
    chk("lb3 wb_data", ifc.wb_data, 32'hFFFFFF80);
    set_req(32'h00000100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    #1;
    run_access("lb0");
    clear_req();
    tick();
    chk("lb0 wb_data", ifc.wb_data, 32'h00000011);

    // SB 0x202
    set_req(32'h00000202, 32'h000000AB, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    run_access("sb");
    chk("sb busy cycles", 32'(busy_cnt), 32'd3);
    chk("sb we cycles", 32'(we_cnt), 32'd2);
    chk("sb oe cycles", 32'(oe_cnt), 32'd0);
    chk("sb be", 32'(seen_be), 32'hB);
    chk("sb wdata", seen_wdata, 32'hABABABAB);
    chk("sb addr", 32'(seen_addr), 32'h00080);
    chk("sb hold we_n", 32'(ifc.ram_we_n), 32'h1);
    chk("sb hold wdata", ifc.ram_wdata, 32'hABABABAB);
    chk("sb hold addr", 32'(ifc.ram_addr), 32'h00080);
    clear_req();
    tick();
    chk("sb wb_rw", 32'(ifc.wb_reg_write), 32'h0);

    // read+write together: the write wins; an LW presented in DONE is accepted after
    set_req(32'h00000300, 32'h55AA55AA, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    run_access("rw");
    chk("rw we cycles", 32'(we_cnt), 32'd2);
    chk("rw oe cycles", 32'(oe_cnt), 32'd0);
    chk("rw be", 32'(seen_be), 32'h0);
    chk("rw wdata", seen_wdata, 32'h55AA55AA);
    ifc.ram_rdata = 32'h11223344;
    set_req(32'h00000304, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9);
    #1;
    chk("b2b done busy", 32'(ifc.mem_busy), 32'h0);
    chk("b2b done ce", 32'(ifc.ram_ce_n), 32'h1);
    tick();
    chk("b2b idle busy", 32'(ifc.mem_busy), 32'h1);
    chk("b2b idle ce", 32'(ifc.ram_ce_n), 32'h1);
    chk("b2b store wb_rw", 32'(ifc.wb_reg_write), 32'h0);
    run_access("b2b");
    chk("b2b busy cycles", 32'(busy_cnt), 32'd3);
    chk("b2b addr", 32'(seen_addr), 32'h000C1);
    clear_req();
    tick();
    chk("b2b wb_data", ifc.wb_data, 32'h11223344);
    chk("b2b wb_reg", 32'(ifc.wb_reg), 32'd9);
    chk("b2b wb_rw", 32'(ifc.wb_reg_write), 32'h1);

    // reset in the second RD cycle
    ifc.ram_rdata = 32'hCAFEF00D;
    set_req(32'h00000400, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    tick();
    chk("mrst in rd", 32'(ifc.ram_oe_n), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mrst ce_n", 32'(ifc.ram_ce_n), 32'h1);
    chk("mrst oe_n", 32'(ifc.ram_oe_n), 32'h1);
    chk("mrst wb_rw", 32'(ifc.wb_reg_write), 32'h0);
    chk("mrst wb_data", ifc.wb_data, 32'h0);
    clear_req();
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("mrst after ce_n", 32'(ifc.ram_ce_n), 32'h1);
    chk("mrst after busy", 32'(ifc.mem_busy), 32'h0);
    chk("mrst after wb_rw", 32'(ifc.wb_reg_write), 32'h0);
    chk("mrst after wb_data", ifc.wb_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
